// File: rtl/sha2_add_pkg.sv
// Shared widths and carry-save tree sizing for the SHA-2 multi-operand adder.
package sha2_add_pkg;

    localparam int WORD_W       = 64;
    localparam int LANE_W       = 32;
    localparam int MAX_OPERANDS = 8;

    // Rows left after one 3:2 level: each full triple becomes two rows, leftovers pass through.
    function automatic int csa_next_rows(input int rows);
        return (rows / 3) * 2 + (rows % 3);
    endfunction

    // Number of 3:2 levels needed to bring num_operands rows down to two (4 for 8 operands).
    function automatic int csa_levels(input int num_operands);
        int rows;
        int levels;
        rows   = num_operands;
        levels = 0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (rows > 2) begin
                rows   = csa_next_rows(rows);
                levels = levels + 1;
            end
        end
        return levels;
    endfunction

endpackage

// File: rtl/csa_tree_mod.sv
// Combinational carry-save tree: reduces NUM_OPERANDS words to a sum/carry pair.
// Every compressor drops the carry out of the top bit (modulo 2^WORD_W) and, in
// dual-lane mode, also drops the carry that would cross from the low lane into
// bit LANE_W, so each 32-bit lane reduces independently.
module csa_tree_mod #(
    parameter int NUM_OPERANDS = 5,
    parameter int WORD_W       = sha2_add_pkg::WORD_W
) (
    input  logic                           mode64_i,
    input  logic [WORD_W*NUM_OPERANDS-1:0] ops_i,
    output logic [WORD_W-1:0]              s_o,
    output logic [WORD_W-1:0]              c_o
);
    import sha2_add_pkg::*;

    localparam int LEVELS = csa_levels(NUM_OPERANDS);

    // Lane-aware 3:2 compressor.
    function automatic void compress_3_2(
        input  logic [WORD_W-1:0] a,
        input  logic [WORD_W-1:0] b,
        input  logic [WORD_W-1:0] c,
        input  logic              mode64,
        output logic [WORD_W-1:0] sum,
        output logic [WORD_W-1:0] carry
    );
        sum   = a ^ b ^ c;
        carry = ((a & b) | (a & c) | (b & c)) << 1;
        if (!mode64) begin
            carry[LANE_W] = 1'b0;
        end
    endfunction

    // Level-by-level reduction; row counts per level are fixed by NUM_OPERANDS,
    // so the loops unroll into a static tree.
    // NOTE: every variable here is fully assigned before it is read on each
    // evaluation, so the block stays purely combinational with no latches.
    always_comb begin
        logic [WORD_W-1:0] rows [NUM_OPERANDS];
        logic [WORD_W-1:0] nxt  [NUM_OPERANDS];
        int                n_rows;
        int                n_groups;

        n_rows   = NUM_OPERANDS;
        n_groups = 0;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            rows[k] = ops_i[k*WORD_W +: WORD_W];
            nxt[k]  = '0;
        end

        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            n_groups = n_rows / 3;
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                nxt[k] = '0;
            end
            for (int g = 0; g < NUM_OPERANDS / 3; g++) begin
                if (g < n_groups) begin
                    compress_3_2(rows[3*g], rows[3*g+1], rows[3*g+2], mode64_i,
                                 nxt[2*g], nxt[2*g+1]);
                end
            end
            // Leftover rows (fewer than three) pass straight to the next level.
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                if (k >= 3 * n_groups && k < n_rows) begin
                    nxt[k - n_groups] = rows[k];
                end
            end
            n_rows = 2 * n_groups + (n_rows % 3);
            rows   = nxt;
        end

        s_o = rows[0];
        c_o = rows[1];
    end

endmodule

// File: rtl/add_multi_operand_pipe.sv
// Three-stage multi-operand modular adder for the SHA-2 datapath.
// S1 compresses the operands with a carry-save tree, S2 adds the low 32 bits,
// S3 adds the high 32 bits plus the (mode-gated) low-lane carry. A single
// advance enable stalls the whole pipe when the output is held; bubbles stay
// in place. Legal NUM_OPERANDS range is 2..8.
module add_multi_operand_pipe
    import sha2_add_pkg::*;
#(
    parameter int NUM_OPERANDS = 5,
    parameter int USER_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode64,
    input  logic [WORD_W*NUM_OPERANDS-1:0] in_ops,
    input  logic [USER_W-1:0]              in_user,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_W-1:0]              out_sum,
    output logic                           out_mode64,
    output logic [USER_W-1:0]              out_user
);

    logic en;

    // Stage 1 registers: carry-save pair plus transaction tags.
    logic              v1_q;
    logic [WORD_W-1:0] s1_s_q, s1_c_q;
    logic [WORD_W-1:0] s1_s_d, s1_c_d;
    logic              s1_mode_q;
    logic [USER_W-1:0] s1_user_q;

    // Stage 2 registers: finished low lane, gated carry, untouched high halves.
    logic              v2_q;
    logic [LANE_W-1:0] s2_lo_q, s2_lo_d;
    logic              s2_c32_q, s2_c32_d;
    logic [LANE_W-1:0] s2_shi_q, s2_chi_q;
    logic              s2_mode_q;
    logic [USER_W-1:0] s2_user_q;

    // Stage 3 registers drive the outputs directly.
    logic              v3_q;
    logic [LANE_W-1:0] s3_hi_d;
    logic [WORD_W-1:0] out_sum_q;
    logic              out_mode_q;
    logic [USER_W-1:0] out_user_q;

    assign en         = !v3_q || out_ready;
    assign in_ready   = en;
    assign out_valid  = v3_q;
    assign out_sum    = out_sum_q;
    assign out_mode64 = out_mode_q;
    assign out_user   = out_user_q;

    csa_tree_mod #(
        .NUM_OPERANDS (NUM_OPERANDS),
        .WORD_W       (WORD_W)
    ) u_csa_tree (
        .mode64_i (in_mode64),
        .ops_i    (in_ops),
        .s_o      (s1_s_d),
        .c_o      (s1_c_d)
    );

    // Low-lane add and high-lane add; the low carry only crosses in 64-bit mode.
    always_comb begin
        logic [LANE_W:0] lo_sum;
        lo_sum   = {1'b0, s1_s_q[LANE_W-1:0]} + {1'b0, s1_c_q[LANE_W-1:0]};
        s2_lo_d  = lo_sum[LANE_W-1:0];
        s2_c32_d = lo_sum[LANE_W] & s1_mode_q;
        s3_hi_d  = s2_shi_q + s2_chi_q + {{(LANE_W-1){1'b0}}, s2_c32_q};
    end

    // Stage 1: capture the compressed operands whenever the pipe advances.
    // NOTE: sequential state is written with non-blocking assignments so every
    // stage samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            s1_s_q    <= '0;
            s1_c_q    <= '0;
            s1_mode_q <= 1'b0;
            s1_user_q <= '0;
        end else if (en) begin
            v1_q      <= in_valid;
            s1_s_q    <= s1_s_d;
            s1_c_q    <= s1_c_d;
            s1_mode_q <= in_mode64;
            s1_user_q <= in_user;
        end
    end

    // Stage 2: low 32-bit carry-propagate add.
    // NOTE: data flops are reset along with the valid bits so the outputs and
    // internal state are deterministic right after reset, not just the valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q      <= 1'b0;
            s2_lo_q   <= '0;
            s2_c32_q  <= 1'b0;
            s2_shi_q  <= '0;
            s2_chi_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_user_q <= '0;
        end else if (en) begin
            v2_q      <= v1_q;
            s2_lo_q   <= s2_lo_d;
            s2_c32_q  <= s2_c32_d;
            s2_shi_q  <= s1_s_q[WORD_W-1:LANE_W];
            s2_chi_q  <= s1_c_q[WORD_W-1:LANE_W];
            s2_mode_q <= s1_mode_q;
            s2_user_q <= s1_user_q;
        end
    end

    // Stage 3: high 32-bit add and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_q       <= 1'b0;
            out_sum_q  <= '0;
            out_mode_q <= 1'b0;
            out_user_q <= '0;
        end else if (en) begin
            v3_q       <= v2_q;
            out_sum_q  <= {s3_hi_d, s2_lo_q};
            out_mode_q <= s2_mode_q;
            out_user_q <= s2_user_q;
        end
    end

endmodule

// File: tb/tb_add_multi_operand_pipe.sv
// Self-checking bench: directed cases and backpressure on a 5-operand instance,
// plus random scoreboarded streams on 2-, 4- and 8-operand instances.
module tb_add_multi_operand_pipe;

    localparam int N_MAIN = 5;
    localparam int N_SWEEP_TXNS = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain modular sums of the operand words.
    function automatic logic [63:0] ref_sum(input logic [511:0] ops, input int n, input logic mode64);
        logic [63:0] total;
        logic [31:0] lo;
        logic [31:0] hi;
        total = '0;
        lo    = '0;
        hi    = '0;
        for (int k = 0; k < n; k++) begin
            total = total + ops[k*64 +: 64];
            lo    = lo + ops[k*64 +: 32];
            hi    = hi + ops[k*64+32 +: 32];
        end
        return mode64 ? total : {hi, lo};
    endfunction

    function automatic logic [95:0] pack_res(input logic [63:0] sum, input logic mode, input logic [7:0] user);
        return {23'b0, user, mode, sum};
    endfunction

    // Random word biased toward carry-heavy patterns.
    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0;
            2:       return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- main 5-operand instance ----------------
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode64;
    logic [64*N_MAIN-1:0]  in_ops;
    logic [7:0]            in_user;
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_sum;
    logic                  out_mode64;
    logic [7:0]            out_user;

    add_multi_operand_pipe #(
        .NUM_OPERANDS (N_MAIN),
        .USER_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode64  (in_mode64),
        .in_ops     (in_ops),
        .in_user    (in_user),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_mode64 (out_mode64),
        .out_user   (out_user)
    );

    function automatic logic [63:0] ref_main(input logic [64*N_MAIN-1:0] ops, input logic mode64);
        logic [511:0] w;
        w = '0;
        w[64*N_MAIN-1:0] = ops;
        return ref_sum(w, N_MAIN, mode64);
    endfunction

    // One transaction into an idle pipe; latency counts rising edges from and
    // including the accepting edge up to the edge that presents the result.
    task automatic send_timed(input string tag, input logic [64*N_MAIN-1:0] ops,
                              input logic mode, input logic [7:0] user, input logic [63:0] exp_sum);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_ops    = ops;
        in_mode64 = mode;
        in_user   = user;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 96'(in_ready), 96'd1);
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 96'(lat), 96'd3);
        check({tag, "_result"}, pack_res(out_sum, out_mode64, out_user), pack_res(exp_sum, mode, user));
    endtask

    // ---------------- sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int N = (g == 0) ? 2 : (g == 1) ? 4 : 8;

        logic           rst_s;
        logic           in_valid_s;
        logic           in_ready_s;
        logic           in_mode64_s;
        logic [64*N-1:0] in_ops_s;
        logic [7:0]     in_user_s;
        logic           out_valid_s;
        logic           out_ready_s;
        logic [63:0]    out_sum_s;
        logic           out_mode64_s;
        logic [7:0]     out_user_s;
        bit             done = 1'b0;

        add_multi_operand_pipe #(
            .NUM_OPERANDS (N),
            .USER_W       (8)
        ) dut_s (
            .clk        (clk),
            .rst        (rst_s),
            .in_valid   (in_valid_s),
            .in_ready   (in_ready_s),
            .in_mode64  (in_mode64_s),
            .in_ops     (in_ops_s),
            .in_user    (in_user_s),
            .out_valid  (out_valid_s),
            .out_ready  (out_ready_s),
            .out_sum    (out_sum_s),
            .out_mode64 (out_mode64_s),
            .out_user   (out_user_s)
        );

        initial begin
            logic [95:0]  q [$];
            logic [511:0] w;
            int           sent;
            bit           accepted;
            string        tag;

            tag         = $sformatf("sweep_n%0d", N);
            rst_s       = 1'b0;
            in_valid_s  = 1'b0;
            in_mode64_s = 1'b0;
            in_ops_s    = '0;
            in_user_s   = '0;
            out_ready_s = 1'b0;
            sent        = 0;
            accepted    = 1'b0;
            repeat (2) @(negedge clk);
            rst_s = 1'b1;

            for (int cyc = 0; cyc < 20000; cyc++) begin
                if (sent == N_SWEEP_TXNS && q.size() == 0) break;
                @(negedge clk);
                if (accepted) in_valid_s = 1'b0;
                accepted = 1'b0;
                // A pending set is held until accepted; new sets alternate mode.
                if (!in_valid_s && sent < N_SWEEP_TXNS && $urandom_range(0, 4) != 0) begin
                    for (int k = 0; k < N; k++) in_ops_s[k*64 +: 64] = rand_word();
                    in_mode64_s = (sent % 2 == 0);
                    in_user_s   = 8'(sent);
                    in_valid_s  = 1'b1;
                end
                out_ready_s = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid_s && out_ready_s) begin
                    if (q.size() == 0) begin
                        check({tag, "_unexpected_output"}, 96'd1, 96'd0);
                    end else begin
                        check({tag, "_result"}, pack_res(out_sum_s, out_mode64_s, out_user_s), q.pop_front());
                    end
                end
                if (in_valid_s && in_ready_s) begin
                    w = '0;
                    w[64*N-1:0] = in_ops_s;
                    q.push_back(pack_res(ref_sum(w, N, in_mode64_s), in_mode64_s, in_user_s));
                    sent++;
                    accepted = 1'b1;
                end
            end
            check({tag, "_all_sent"}, 96'(sent), 96'(N_SWEEP_TXNS));
            check({tag, "_drained"}, 96'(q.size()), 96'd0);
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        logic [95:0] q [$];
        logic [319:0] ops_a;
        int          sent;
        int          retired;
        int          stale;
        int          wait_cnt;
        bit          accepted;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_mode64 = 1'b0;
        in_ops    = '0;
        in_user   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 96'(out_valid), 96'd0);
        check("reset_in_ready", 96'(in_ready), 96'd1);
        check("reset_out_sum", 96'(out_sum), 96'd0);
        check("reset_out_mode64", 96'(out_mode64), 96'd0);
        check("reset_out_user", 96'(out_user), 96'd0);
        @(negedge clk);
        rst = 1'b1;

        // Saturated operands in both modes.
        send_timed("ones_mode64", '1, 1'b1, 8'h11, 64'hFFFF_FFFF_FFFF_FFFB);
        send_timed("ones_mode32", '1, 1'b0, 8'h22, 64'hFFFF_FFFB_FFFF_FFFB);

        // Lane isolation: same operands, dual-lane then single-lane, back-to-back.
        ops_a = '0;
        ops_a[63:0]    = 64'h0000_0000_FFFF_FFFF;
        ops_a[127:64]  = 64'h1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ops    = ops_a;
        in_mode64 = 1'b0;
        in_user   = 8'hA0;
        @(negedge clk);
        in_mode64 = 1'b1;
        in_user   = 8'hA1;
        @(negedge clk);
        in_valid  = 1'b0;
        wait_cnt  = 0;
        while (!out_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("lane_iso_dual", pack_res(out_sum, out_mode64, out_user), pack_res(64'h0, 1'b0, 8'hA0));
        @(negedge clk);
        check("lane_iso_single", pack_res(out_sum, out_mode64, out_user),
              pack_res(64'h0000_0001_0000_0000, 1'b1, 8'hA1));
        check("lane_iso_single_valid", 96'(out_valid), 96'd1);

        // Backpressure: 10 random sets, out_ready pattern 1,0,0 repeating.
        sent     = 0;
        retired  = 0;
        accepted = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (sent == 10 && q.size() == 0) break;
            @(negedge clk);
            if (accepted) begin
                in_valid = 1'b0;
                if (sent < 10) begin
                    for (int k = 0; k < N_MAIN; k++) in_ops[k*64 +: 64] = rand_word();
                    in_mode64 = $urandom_range(0, 1) == 1;
                    in_user   = 8'(8'hB0 + sent);
                    in_valid  = 1'b1;
                end
            end
            accepted  = 1'b0;
            out_ready = (cyc % 3 == 0);
            #1;
            check("bp_in_ready", 96'(in_ready), 96'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                retired++;
                if (q.size() == 0) begin
                    check("bp_duplicate_output", 96'd1, 96'd0);
                end else begin
                    check("bp_result", pack_res(out_sum, out_mode64, out_user), q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(pack_res(ref_main(in_ops, in_mode64), in_mode64, in_user));
                sent++;
                accepted = 1'b1;
            end
        end
        check("bp_retired_count", 96'(retired), 96'd10);
        check("bp_queue_empty", 96'(q.size()), 96'd0);

        // Asynchronous reset with three sets in flight.
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int k = 0; k < N_MAIN; k++) in_ops[k*64 +: 64] = rand_word();
            in_mode64 = 1'b1;
            in_user   = 8'(8'hC0 + i);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rst_inflight_valid", 96'(out_valid), 96'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_out_valid", 96'(out_valid), 96'd0);
        check("rst_async_out_sum", 96'(out_sum), 96'd0);
        check("rst_async_in_ready", 96'(in_ready), 96'd1);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale_output", 96'(stale), 96'd0);
        ops_a = '0;
        for (int k = 0; k < N_MAIN; k++) ops_a[k*64 +: 64] = 64'(k + 1) * 64'h0101_0101_0101_0101;
        send_timed("post_reset", ops_a, 1'b1, 8'hD5, 64'h0F0F_0F0F_0F0F_0F0F);

        // Let the parameter sweeps finish.
        wait_cnt = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && wait_cnt < 40000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("sweeps_finished", 96'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 96'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_multi_operand_pipe.md
# add_multi_operand_pipe

Pipelined, parametrised multi-operand modular adder for the SHA-2 datapath (T1/T2 and message-schedule sums). It reduces NUM_OPERANDS words of 64 bits through a carry-save tree and a split 32+32 carry-propagate stage into one modular sum. Per transaction, mode64 selects either one 64-bit lane (SHA-512) or two independent 32-bit lanes (SHA-256). Valid/ready handshakes on both sides and a user sideband let it drop into the round pipeline with backpressure.

## Interface
- NUM_OPERANDS, 5, operand count, legal range 2..8.
- USER_W, 8, sideband width carried alongside each sum, minimum 1.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset. Clears all valid and state flops.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept this cycle.
- in_mode64  in  1  1: one lane modulo 2^64. 0: two lanes, each modulo 2^32, with no carry across bit 31→32.
- in_ops  in  64*NUM_OPERANDS  operand k at bits [64k+63:64k].
- in_user  in  USER_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_sum  out  64  modular sum.
- out_mode64  out  1  mode of this result.
- out_user  out  USER_W  sideband of this result.

## Operation
- Transfer occurs on a rising edge with valid && ready, on both ports.
- Stage S1 (compress):
  - csa_tree_mod reduces the operands to sum/carry vectors S, C.
  - All carry shifts are modulo 64.
  - If mode64=0, the carry shifted into bit 32 is forced to 0.
  - Results are registered with mode and user.
- Stage S2 (low add):
  - {c32, lo} = S[31:0] + C[31:0], a 33-bit add.
  - Register lo, c32 & mode64, S[63:32], C[63:32], mode and user.
- Stage S3 (high add):
  - hi = S[63:32] + C[63:32] + gated c32, modulo 2^32.
  - Register out_sum = {hi, lo}.
- Arithmetic rules:
  - mode64=1: out_sum = Σ ops mod 2^64.
  - mode64=0: out_sum[31:0] = Σ ops[31:0] mod 2^32, and out_sum[63:32] = Σ ops[63:32] mod 2^32.
- Mode is per transaction. Back-to-back transactions with different modes must not interfere.
- Flow control:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en, which is combinational from out_valid/out_ready.
  - When en=0, every stage register and its valid bit hold.
  - Bubbles are not collapsed. A stalled pipeline holds empty slots in place.
- No internal state machine beyond the three stage valid bits v1, v2, v3 (out_valid = v3).
- Reset values:
  - v1, v2, v3 = 0, so out_valid = 0.
  - in_ready = 1.
  - out_sum = 0, out_mode64 = 0, out_user = 0.
  - Data flops are reset too, for determinism.
- Reset mid-operation: all in-flight transactions are discarded and nothing is emitted after reset. The first input accepted after reset deassertion is processed normally.

## Timing
- Latency 3 cycles: a set accepted at edge t is presented with out_valid=1 after edge t+3, if no stall occurred.
- Throughput is 1 transaction per cycle while out_ready=1.
- A stall of k cycles adds exactly k cycles to every in-flight transaction's latency. Ordering is always preserved.
- Simultaneous events:
  - out_ready rising while in_valid=1: the input is accepted on the same edge the output retires.
  - in_valid=1 with in_ready=0: the input is not accepted, and the source must hold it.
- Critical paths:
  - S1 is the tree depth: ≤ 4 CSA levels for NUM_OPERANDS ≤ 8.
  - S2 and S3 are each a 32-bit adder, sized to map to one DSP/carry chain per stage.

## Structure
- Package sha2_add_pkg holds:
  - WORD_W=64 and LANE_W=32.
  - MAX_OPERANDS=8.
  - A function that returns the number of CSA levels for a given operand count.
- Sub-module csa_tree_mod:
  - Combinational.
  - Parameters NUM_OPERANDS and WORD_W.
  - Input mode64; outputs S, C.
  - Built from lane-aware 3:2 compressors (4:2 when the operand count allows).
  - Verified standalone against a behavioural sum.

## Test plan
- NUM_OPERANDS=5, mode64=1, all ops 0xFFFF_FFFF_FFFF_FFFF → out_sum 0xFFFF_FFFF_FFFF_FFFB, exactly 3 cycles after acceptance.
- Same operands with mode64=0 → 0xFFFF_FFFB_FFFF_FFFB.
- Lane isolation, with op0=0x0000_0000_FFFF_FFFF, op1=0x1, others 0:
  - mode64=0 → 0x0000_0000_0000_0000.
  - The next transaction with mode64=1 → 0x0000_0001_0000_0000.
  - Both sent back-to-back.
- Backpressure:
  - Stream 10 random sets with out_ready toggling 1,0,0,1,…
  - Required: in_ready tracks en, no loss, no duplication, order and user tags preserved, sums match the model.
- Reset: assert rst low with 3 transactions in flight → out_valid=0 and out_sum=0 immediately (asynchronous). After release, no stale output appears, and a new set returns its result after 3 cycles.
- Parameter sweep NUM_OPERANDS ∈ {2,4,8}: 1000 random sets in each mode, scoreboard against the modular reference sum.
